execute_muldiv_stage: RTL and testbench
=======================================

Name: execute_muldiv_stage

Overview:
Parametrised successor to the single-shot execute stage. Adds valid/ready handshakes on both sides, output back-pressure, pipeline flush, and an iterative RV32M multiply/divide datapath. Sits between decode/register-read and MEM. Single-cycle ALU, branch, jump, LUI/AUIPC and address ops share the output register with multi-cycle MUL/DIV results.

Parameters:
XLEN, 32, datapath width (32 or 64).
ITER_BITS, 1, quotient/product bits resolved per iteration cycle; must divide XLEN (1, 2, 4).
ITER_CYCLES, XLEN/ITER_BITS, derived localparam; not overridable.

Ports:
i_clk  in  1  clock, rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_flush  in  1  kill in-flight and held instruction.
i_valid  in  1  upstream instruction valid.
o_ready  out  1  stage accepts an instruction this cycle.
i_pc  in  XLEN  instruction PC.
i_control_signal  in  control_s  decoded controls (alu_imm, alu_reg, cond_branch, uncond_branch, load_upper_imm, mem, muldiv, iop, fcs_opcode).
i_rs1, i_rs2, i_imm  in  XLEN  operands; i_imm is already sign-extended, U-type pre-shifted.
o_valid  out  1  result valid.
i_ready  in  1  downstream accepts the result.
o_control_signal  out  control_s  control signals of the result instruction.
o_rd_output  out  XLEN  rd value or memory address.
o_rs2  out  XLEN  store data.
o_pc_ext  out  XLEN  redirect target.
o_pc_load  out  1  redirect taken; qualified by o_valid.
o_state  out  EX_MD_state_t  current state, for verification only.

Behaviour:
- Reset (async assert, sync release): state EX_IDLE. o_valid=0, o_pc_load=0, o_rd_output=0, o_pc_ext=0, o_rs2=0, o_control_signal=control_s_default(). Iteration counter=0.
- States:
  - EX_IDLE: empty.
  - EX_ITER: MUL/DIV iterating.
  - EX_HOLD: result registered, o_valid=1.
- o_ready = (state==EX_IDLE) | (state==EX_HOLD & i_ready). Accept = i_valid & o_ready & ~i_flush.
- Non-muldiv accept: result computed combinationally and registered on the accept edge. Next state EX_HOLD; latency 1.
- Muldiv accept: operands latched, counter=ITER_CYCLES, next state EX_ITER. Counter decrements each cycle; at 1, result is registered and state goes to EX_HOLD. Latency ITER_CYCLES+1.
- DIV/REM fast path, no iteration (latency 1):
  - Divisor 0: DIV/DIVU=all ones; REM/REMU=dividend.
  - Signed overflow (MIN / -1): DIV=MIN, REM=0.
- EX_HOLD & i_ready & no accept: transition to EX_IDLE, o_valid=0. EX_HOLD & i_ready & accept: back-to-back, no bubble.
- Output registers hold stable while o_valid & ~i_ready.
- i_flush has highest priority in any state: next state EX_IDLE, o_valid=0, iteration aborted, same-cycle i_valid dropped.
- ALU (alu_imm selects i_imm, else rs2), fcs_opcode:
  - 000: ADD; SUB when iop & alu_reg.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when iop.
  - 110: OR.
  - 111: AND.
  - Shift amount is operand[$clog2(XLEN)-1:0].
- Branch: compare rs1 vs rs2 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111). Taken: o_pc_load=1, o_pc_ext=pc+imm. Not taken: o_pc_load=0, o_pc_ext=pc+4.
- JAL (fcs 010): rd=pc+4, target pc+imm. JALR (fcs 011): rd=pc+4, target (rs1+imm)&~1. Both set o_pc_load=1.
- LUI (iop=1): rd=imm. AUIPC: rd=pc+imm.
- mem: rd=rs1+imm, o_rs2=rs2.
- Muldiv fcs_opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Signed ops iterate on magnitudes and fix the sign at completion.
  - All arithmetic is modulo 2^XLEN; the high-product uses a 2*XLEN accumulator.
- o_pc_load and o_pc_ext are 0 for all non-branch/jump instructions.

Optional Feature:
EX_PERF_CNT_EN: adds outputs o_stall_cycles and o_muldiv_count (32-bit each). They count cycles with o_valid & ~i_ready, and muldiv instructions completed, respectively. Counters reset to 0, saturate at all ones, and do not change on flush. Without the macro the ports and counters do not exist.

Decomposition:
- rapid_pkg gains:
  - the EX_MD_state_t enum;
  - the muldiv field in control_s, with control_s_default() updated;
  - MULDIV funct3 constants;
  - the ALU, branch and load/store funct3 constants, moved out of file scope.
- One sub-module, muldiv_iter: owns the operand and accumulator registers, the counter, and the fast paths. Interface is start/done/flush.

Test Plan:
- ADDI rs1=5, imm=-7, i_ready=1 -> one cycle later o_valid=1, rd=0xFFFFFFFE; next cycle o_valid=0.
- SRA rs1=0x80000000, rs2=4 -> rd=0xF8000000. SRL same operands -> rd=0x08000000.
- BLT rs1=-1, rs2=1, pc=0x100, imm=0x20 -> o_pc_load=1, o_pc_ext=0x120. BLTU same operands -> o_pc_load=0, o_pc_ext=0x104.
- MULH 0x80000000 x 2 with ITER_BITS=1 -> o_valid after 33 cycles, rd=0xFFFFFFFF. DIV 7/0 -> rd=0xFFFFFFFF after 1 cycle. REM 0x80000000 % -1 -> rd=0.
- Back-pressure: i_ready=0 for 5 cycles with a result held -> outputs stable, o_ready=0. Release with i_valid=1 -> new instruction accepted the same cycle, no bubble.
- DIVU issued, i_flush at iteration 10 -> EX_IDLE the next cycle, o_valid stays 0. A following ADD completes correctly. Assert i_reset_n low mid-iteration -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rapid_pkg.sv
// Shared types and funct3 encodings for the execute stage and its muldiv unit.
package rapid_pkg;

    // Decoded control bundle carried alongside each instruction
    typedef struct packed {
        logic       alu_imm;
        logic       alu_reg;
        logic       cond_branch;
        logic       uncond_branch;
        logic       load_upper_imm;
        logic       mem;
        logic       muldiv;
        logic       iop;
        logic [2:0] fcs_opcode;
    } control_s;

    function automatic control_s control_s_default();
        control_s c;
        c = '0;
        return c;
    endfunction

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_ITER = 2'd1,
        EX_HOLD = 2'd2
    } EX_MD_state_t;

    // ALU funct3
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Unconditional jump selector
    localparam logic [2:0] JMP_JAL  = 3'b010;
    localparam logic [2:0] JMP_JALR = 3'b011;

    // Load/store funct3
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // RV32M funct3
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes,
// ITER_BITS steps per cycle, sign fixed on the final cycle. DIV/REM corner
// cases (zero divisor, MIN/-1) are flagged combinationally so the caller can
// retire them without starting an iteration.
module muldiv_iter
    import rapid_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ITER_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_fast,
    output logic [XLEN-1:0] o_fast_result,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned ITER_CYCLES = XLEN / ITER_BITS;
    localparam int unsigned CNT_W       = $clog2(ITER_CYCLES + 1);
    localparam logic [XLEN-1:0] XMIN    = {1'b1, {(XLEN-1){1'b0}}};

    // acc holds {hi, lo}: product accumulator or {remainder, quotient}
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
    logic [XLEN-1:0]   b_q, b_d, a_mag, b_mag, part;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN:0]     rem_sh, sum;

    // Operand decode and the non-iterating DIV/REM cases
    always_comb begin
        is_div   = i_op[2];
        is_rem   = i_op[2] & i_op[1];
        a_signed = is_div ? ~i_op[0] : ((i_op == MD_MULH) | (i_op == MD_MULHSU));
        b_signed = is_div ? ~i_op[0] : (i_op == MD_MULH);
        a_neg    = a_signed & i_a[XLEN-1];
        b_neg    = b_signed & i_b[XLEN-1];
        a_mag    = a_neg ? -i_a : i_a;
        b_mag    = b_neg ? -i_b : i_b;
        o_fast        = 1'b0;
        o_fast_result = '0;
        if (is_div && (i_b == '0)) begin
            o_fast        = 1'b1;
            o_fast_result = is_rem ? i_a : '1;
        end else if (is_div && !i_op[0] && (i_a == XMIN) && (i_b == '1)) begin
            o_fast        = 1'b1;
            o_fast_result = is_rem ? '0 : XMIN;
        end
    end

    // One cycle worth of iteration steps applied to the current accumulator
    always_comb begin
        acc_step = acc_q;
        rem_sh   = '0;
        sum      = '0;
        for (int k = 0; k < int'(ITER_BITS); k++) begin
            if (op_q[2]) begin
                rem_sh = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
                acc_step[XLEN-1:0] = {acc_step[XLEN-2:0], 1'b0};
                if (rem_sh >= {1'b0, b_q}) begin
                    rem_sh      = rem_sh - {1'b0, b_q};
                    acc_step[0] = 1'b1;
                end
                acc_step[2*XLEN-1:XLEN] = rem_sh[XLEN-1:0];
            end else begin
                sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, b_q} : '0);
                acc_step = {sum, acc_step[XLEN-1:1]};
            end
        end
    end

    // Result selection with sign correction on the final step
    always_comb begin
        prod = neg_q ? -acc_step : acc_step;
        part = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        if (op_q[2]) begin
            o_result = neg_q ? -part : part;
        end else if (op_q[1:0] == 2'b00) begin
            o_result = prod[XLEN-1:0];
        end else begin
            o_result = prod[2*XLEN-1:XLEN];
        end
        o_done = (cnt_q == CNT_W'(1));
    end

    // Load on start, step while the counter runs, abort on flush
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        op_d  = op_q;
        neg_d = neg_q;
        cnt_d = cnt_q;
        if (i_flush) begin
            cnt_d = '0;
        end else if (i_start) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            b_d   = b_mag;
            op_d  = i_op;
            neg_d = is_rem ? a_neg : (a_neg ^ b_neg);
            cnt_d = CNT_W'(ITER_CYCLES);
        end else if (cnt_q != '0) begin
            acc_d = acc_step;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Iteration state registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            op_q  <= op_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/execute_muldiv_stage.sv
// Execute stage with valid/ready handshakes, flush and an iterative RV32M unit.
// Single-cycle ops retire one cycle after accept; MUL/DIV occupy EX_ITER.
// Optional macro EX_PERF_CNT_EN adds o_stall_cycles / o_muldiv_count.
module execute_muldiv_stage
    import rapid_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ITER_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  control_s        i_control_signal,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_valid,
    input  logic            i_ready,
    output control_s        o_control_signal,
    output logic [XLEN-1:0] o_rd_output,
    output logic [XLEN-1:0] o_rs2,
    output logic [XLEN-1:0] o_pc_ext,
    output logic            o_pc_load,
`ifdef EX_PERF_CNT_EN
    output logic [31:0]     o_stall_cycles,
    output logic [31:0]     o_muldiv_count,
`endif
    output EX_MD_state_t    o_state
);

    localparam int unsigned SHW = $clog2(XLEN);

    EX_MD_state_t    state_q, state_d;
    control_s        ctrl_q, ctrl_d;
    logic [XLEN-1:0] rd_q, rd_d, rs2_q, rs2_d, pc_ext_q, pc_ext_d;
    logic            pc_load_q, pc_load_d;
    logic            accept, md_start, md_fast, md_done;
    logic [XLEN-1:0] md_fast_result, md_result;
    logic [XLEN-1:0] op2, pc_plus4, alu_res, ex_rd, ex_pc_ext;
    logic [SHW-1:0]  shamt;
    logic            br_taken, ex_pc_load;

    muldiv_iter #(
        .XLEN      (XLEN),
        .ITER_BITS (ITER_BITS)
    ) u_muldiv (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (md_start),
        .i_flush       (i_flush),
        .i_op          (i_control_signal.fcs_opcode),
        .i_a           (i_rs1),
        .i_b           (i_rs2),
        .o_fast        (md_fast),
        .o_fast_result (md_fast_result),
        .o_done        (md_done),
        .o_result      (md_result)
    );

    assign o_ready = (state_q == EX_IDLE) | ((state_q == EX_HOLD) & i_ready);
    assign accept  = i_valid & o_ready & ~i_flush;

    // Single-cycle ALU / branch / jump / upper-immediate / address result
    always_comb begin
        op2      = i_control_signal.alu_imm ? i_imm : i_rs2;
        shamt    = op2[SHW-1:0];
        pc_plus4 = i_pc + XLEN'(4);
        alu_res  = '0;
        br_taken = 1'b0;
        case (i_control_signal.fcs_opcode)
            ALU_ADD:  alu_res = (i_control_signal.iop & i_control_signal.alu_reg) ?
                                i_rs1 - op2 : i_rs1 + op2;
            ALU_SLL:  alu_res = i_rs1 << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(i_rs1) < $signed(op2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, i_rs1 < op2};
            ALU_XOR:  alu_res = i_rs1 ^ op2;
            ALU_SR:   alu_res = i_control_signal.iop ? XLEN'($signed(i_rs1) >>> shamt) :
                                i_rs1 >> shamt;
            ALU_OR:   alu_res = i_rs1 | op2;
            ALU_AND:  alu_res = i_rs1 & op2;
            default:  alu_res = '0;
        endcase
        case (i_control_signal.fcs_opcode)
            BR_BEQ:  br_taken = (i_rs1 == i_rs2);
            BR_BNE:  br_taken = (i_rs1 != i_rs2);
            BR_BLT:  br_taken = ($signed(i_rs1) < $signed(i_rs2));
            BR_BGE:  br_taken = ($signed(i_rs1) >= $signed(i_rs2));
            BR_BLTU: br_taken = (i_rs1 < i_rs2);
            BR_BGEU: br_taken = (i_rs1 >= i_rs2);
            default: br_taken = 1'b0;
        endcase
        ex_rd      = alu_res;
        ex_pc_ext  = '0;
        ex_pc_load = 1'b0;
        if (i_control_signal.cond_branch) begin
            ex_rd      = '0;
            ex_pc_load = br_taken;
            ex_pc_ext  = br_taken ? i_pc + i_imm : pc_plus4;
        end else if (i_control_signal.uncond_branch) begin
            ex_rd      = pc_plus4;
            ex_pc_load = 1'b1;
            ex_pc_ext  = (i_control_signal.fcs_opcode == JMP_JALR) ?
                         ((i_rs1 + i_imm) & ~XLEN'(1)) : i_pc + i_imm;
        end else if (i_control_signal.load_upper_imm) begin
            ex_rd = i_control_signal.iop ? i_imm : i_pc + i_imm;
        end else if (i_control_signal.mem) begin
            ex_rd = i_rs1 + i_imm;
        end
    end

    // Next state and output-register updates; flush overrides everything
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        rs2_d     = rs2_q;
        pc_ext_d  = pc_ext_q;
        pc_load_d = pc_load_q;
        md_start  = 1'b0;
        if (i_flush) begin
            state_d   = EX_IDLE;
            pc_load_d = 1'b0;
        end else begin
            case (state_q)
                EX_IDLE, EX_HOLD: begin
                    if (accept) begin
                        ctrl_d = i_control_signal;
                        rs2_d  = i_rs2;
                        if (i_control_signal.muldiv) begin
                            pc_ext_d  = '0;
                            pc_load_d = 1'b0;
                            if (md_fast) begin
                                rd_d    = md_fast_result;
                                state_d = EX_HOLD;
                            end else begin
                                md_start = 1'b1;
                                state_d  = EX_ITER;
                            end
                        end else begin
                            rd_d      = ex_rd;
                            pc_ext_d  = ex_pc_ext;
                            pc_load_d = ex_pc_load;
                            state_d   = EX_HOLD;
                        end
                    end else if ((state_q == EX_HOLD) && i_ready) begin
                        state_d = EX_IDLE;
                    end
                end
                EX_ITER: begin
                    if (md_done) begin
                        rd_d    = md_result;
                        state_d = EX_HOLD;
                    end
                end
                default: state_d = EX_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= EX_IDLE;
            ctrl_q    <= control_s_default();
            rd_q      <= '0;
            rs2_q     <= '0;
            pc_ext_q  <= '0;
            pc_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            rs2_q     <= rs2_d;
            pc_ext_q  <= pc_ext_d;
            pc_load_q <= pc_load_d;
        end
    end

    assign o_valid          = (state_q == EX_HOLD);
    assign o_state          = state_q;
    assign o_control_signal = ctrl_q;
    assign o_rd_output      = rd_q;
    assign o_rs2            = rs2_q;
    assign o_pc_ext         = pc_ext_q;
    assign o_pc_load        = pc_load_q;

`ifdef EX_PERF_CNT_EN
    logic [31:0] stall_q, stall_d, mdc_q, mdc_d;
    logic        md_complete;

    // Saturating counters; cycles with flush asserted leave them untouched
    always_comb begin
        stall_d     = stall_q;
        mdc_d       = mdc_q;
        md_complete = ~i_flush & (((state_q == EX_ITER) & md_done) |
                                  (accept & i_control_signal.muldiv & md_fast));
        if (!i_flush && o_valid && !i_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (md_complete && (mdc_q != '1)) begin
            mdc_d = mdc_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_q <= '0;
            mdc_q   <= '0;
        end else begin
            stall_q <= stall_d;
            mdc_q   <= mdc_d;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_muldiv_count = mdc_q;
`endif

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Directed bench for execute_muldiv_stage (XLEN=32, ITER_BITS=1).
module tb_execute_muldiv_stage;
    import rapid_pkg::*;

    // Control flag bits in control_s field order (fcs_opcode appended below)
    localparam logic [7:0] F_IMM = 8'h80;
    localparam logic [7:0] F_REG = 8'h40;
    localparam logic [7:0] F_BR  = 8'h20;
    localparam logic [7:0] F_JMP = 8'h10;
    localparam logic [7:0] F_LUI = 8'h08;
    localparam logic [7:0] F_MEM = 8'h04;
    localparam logic [7:0] F_MD  = 8'h02;
    localparam logic [7:0] F_IOP = 8'h01;

    logic         i_clk = 1'b0;
    logic         i_reset_n, i_flush, i_valid, i_ready;
    logic         o_ready, o_valid, o_pc_load;
    logic [31:0]  i_pc, i_rs1, i_rs2, i_imm;
    logic [31:0]  o_rd_output, o_rs2, o_pc_ext;
    control_s     i_control_signal, o_control_signal;
    EX_MD_state_t o_state;
`ifdef EX_PERF_CNT_EN
    logic [31:0]  o_stall_cycles, o_muldiv_count;
`endif

    int checks = 0;
    int errors = 0;

    execute_muldiv_stage #(
        .XLEN      (32),
        .ITER_BITS (1)
    ) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_flush          (i_flush),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_pc             (i_pc),
        .i_control_signal (i_control_signal),
        .i_rs1            (i_rs1),
        .i_rs2            (i_rs2),
        .i_imm            (i_imm),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_control_signal (o_control_signal),
        .o_rd_output      (o_rd_output),
        .o_rs2            (o_rs2),
        .o_pc_ext         (o_pc_ext),
        .o_pc_load        (o_pc_load),
`ifdef EX_PERF_CNT_EN
        .o_stall_cycles   (o_stall_cycles),
        .o_muldiv_count   (o_muldiv_count),
`endif
        .o_state          (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic present(input logic [7:0] fl, input logic [2:0] fcs, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        i_control_signal = control_s'({fl, fcs});
        i_pc    = pc;
        i_rs1   = rs1;
        i_rs2   = rs2;
        i_imm   = imm;
        i_valid = 1'b1;
    endtask

    // Present for exactly one edge, then drop valid
    task automatic issue(input logic [7:0] fl, input logic [2:0] fcs, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        present(fl, fcs, pc, rs1, rs2, imm);
        tick();
        i_valid = 1'b0;
    endtask

    // Iterating muldiv: busy for 32 edges after accept, result on the 33rd
    task automatic run_md(input string tag, input logic [2:0] fcs, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(F_MD, fcs, 32'h0, a, b, 32'h0);
        repeat (31) tick();
        check({tag, "_busy_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_busy_ready"}, 64'(o_ready), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_rd"}, 64'(o_rd_output), 64'(exp));
        tick();
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_flush   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_pc      = '0;
        i_rs1     = '0;
        i_rs2     = '0;
        i_imm     = '0;
        i_control_signal = control_s_default();
        #2;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_rd", 64'(o_rd_output), 64'd0);
        check("rst_state", 64'(o_state), 64'(EX_IDLE));
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_pc_load", 64'(o_pc_load), 64'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();

        // ADDI 5 + (-7)
        issue(F_IMM, ALU_ADD, 32'h0, 32'd5, 32'h0, 32'hFFFF_FFF9);
        check("addi_valid", 64'(o_valid), 64'd1);
        check("addi_rd", 64'(o_rd_output), 64'hFFFF_FFFE);
        check("addi_pc_load", 64'(o_pc_load), 64'd0);
        tick();
        check("addi_drain", 64'(o_valid), 64'd0);

        // SRA then SRL back-to-back
        issue(F_REG | F_IOP, ALU_SR, 32'h0, 32'h8000_0000, 32'd4, 32'h0);
        check("sra_rd", 64'(o_rd_output), 64'hF800_0000);
        issue(F_REG, ALU_SR, 32'h0, 32'h8000_0000, 32'd4, 32'h0);
        check("srl_valid", 64'(o_valid), 64'd1);
        check("srl_rd", 64'(o_rd_output), 64'h0800_0000);
        issue(F_REG | F_IOP, ALU_ADD, 32'h0, 32'd3, 32'd5, 32'h0);
        check("sub_rd", 64'(o_rd_output), 64'hFFFF_FFFE);
        issue(F_REG, ALU_SLT, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("slt_rd", 64'(o_rd_output), 64'd1);
        issue(F_REG, ALU_SLTU, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("sltu_rd", 64'(o_rd_output), 64'd0);

        // Branches, jumps, upper-immediate, address
        issue(F_BR, BR_BLT, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        check("blt_load", 64'(o_pc_load), 64'd1);
        check("blt_ext", 64'(o_pc_ext), 64'h120);
        issue(F_BR, BR_BLTU, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        check("bltu_load", 64'(o_pc_load), 64'd0);
        check("bltu_ext", 64'(o_pc_ext), 64'h104);
        issue(F_JMP, JMP_JAL, 32'h200, 32'h0, 32'h0, 32'h40);
        check("jal_rd", 64'(o_rd_output), 64'h204);
        check("jal_ext", 64'(o_pc_ext), 64'h240);
        check("jal_load", 64'(o_pc_load), 64'd1);
        issue(F_JMP, JMP_JALR, 32'h300, 32'h1001, 32'h0, 32'h10);
        check("jalr_ext", 64'(o_pc_ext), 64'h1010);
        issue(F_LUI | F_IOP, 3'b000, 32'h1000, 32'h0, 32'h0, 32'h1234_5000);
        check("lui_rd", 64'(o_rd_output), 64'h1234_5000);
        check("lui_pc_load", 64'(o_pc_load), 64'd0);
        check("lui_pc_ext", 64'(o_pc_ext), 64'd0);
        issue(F_LUI, 3'b000, 32'h1000, 32'h0, 32'h0, 32'h2000);
        check("auipc_rd", 64'(o_rd_output), 64'h3000);
        issue(F_MEM, LS_W, 32'h0, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("mem_addr", 64'(o_rd_output), 64'hFC);
        check("mem_rs2", 64'(o_rs2), 64'hDEAD_BEEF);
        tick();

        // Iterative multiply / divide
        run_md("mulh", MD_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
        run_md("mul", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_md("rem", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_md("remu", MD_REMU, 32'd100, 32'd7, 32'd2);

        // Fast paths retire on the accept edge
        issue(F_MD, MD_DIV, 32'h0, 32'd7, 32'd0, 32'h0);
        check("div0_valid", 64'(o_valid), 64'd1);
        check("div0_rd", 64'(o_rd_output), 64'hFFFF_FFFF);
        issue(F_MD, MD_REM, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        check("removf_rd", 64'(o_rd_output), 64'd0);
        issue(F_MD, MD_DIV, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        check("divovf_rd", 64'(o_rd_output), 64'h8000_0000);
        issue(F_MD, MD_REMU, 32'h0, 32'd9, 32'd0, 32'h0);
        check("remu0_rd", 64'(o_rd_output), 64'd9);
        tick();

        // Back-pressure: result held, pending instruction waits, then no bubble
        i_ready = 1'b0;
        issue(F_REG, ALU_ADD, 32'h0, 32'd1, 32'd2, 32'h0);
        check("bp_first", 64'(o_rd_output), 64'd3);
        present(F_REG, ALU_XOR, 32'h0, 32'hF0, 32'h0F, 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 64'(o_valid), 64'd1);
            check("bp_hold_rd", 64'(o_rd_output), 64'd3);
            check("bp_hold_ready", 64'(o_ready), 64'd0);
        end
        i_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        check("bp_next_valid", 64'(o_valid), 64'd1);
        check("bp_next_rd", 64'(o_rd_output), 64'hFF);
        tick();
        check("bp_drain", 64'(o_valid), 64'd0);

        // Flush mid-iteration, with a same-cycle instruction that must be dropped
        issue(F_MD, MD_DIVU, 32'h0, 32'd100, 32'd7, 32'h0);
        repeat (9) tick();
        i_flush = 1'b1;
        present(F_REG, ALU_ADD, 32'h0, 32'd1, 32'd1, 32'h0);
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_state", 64'(o_state), 64'(EX_IDLE));
        check("flush_valid", 64'(o_valid), 64'd0);
        repeat (30) tick();
        check("flush_aborted", 64'(o_valid), 64'd0);
        issue(F_REG, ALU_ADD, 32'h0, 32'd10, 32'd20, 32'h0);
        check("post_flush_rd", 64'(o_rd_output), 64'd30);
        tick();

        // Asynchronous reset mid-iteration
        issue(F_MD, MD_MUL, 32'h0, 32'd3, 32'd4, 32'h0);
        repeat (5) tick();
        check("pre_rst_state", 64'(o_state), 64'(EX_ITER));
        i_reset_n = 1'b0;
        #1;
        check("arst_state", 64'(o_state), 64'(EX_IDLE));
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_rd", 64'(o_rd_output), 64'd0);
        check("arst_rs2", 64'(o_rs2), 64'd0);
        check("arst_ctrl", 64'(o_control_signal), 64'(control_s_default()));
        @(negedge i_clk);
        i_reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
